// File: rtl/mm_result_collector.sv
// Collects the word-serial Montgomery S output and streams the K-bit result on valid/ready.
// Define MM_FINAL_SUB_EN to add the final conditional subtraction (S >= M ? S-M : S).
module mm_result_collector #(
  parameter int K          = 1024,
  parameter int W          = 16,
  parameter int SAMPLE_GAP = W/2-1,
  parameter int START_LAT  = 527
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         START,
  input  logic [W-1:0] M_IN,
  input  logic         M_VALID,
  input  logic [W-1:0] S_IN,
  output logic [W-1:0] OUT_DATA,
  output logic         OUT_VALID,
  input  logic         OUT_READY,
  output logic         OUT_LAST,
  output logic         BUSY,
  output logic         DONE
);
  localparam int NW = K/W+1;
  localparam int IW = $clog2(NW+1);
  localparam int GW = (SAMPLE_GAP > 1) ? $clog2(SAMPLE_GAP) : 1;
  localparam int LW = (START_LAT > 1) ? $clog2(START_LAT) : 1;

  localparam logic [IW-1:0] LAST_W   = IW'(NW-1);
  localparam logic [LW-1:0] LAT_INIT = LW'(START_LAT-1);
  localparam logic [GW-1:0] GAP_END  = GW'(SAMPLE_GAP-1);
`ifdef MM_FINAL_SUB_EN
  localparam logic [IW-1:0] LAST_OUT = IW'(NW-2);
  localparam logic [IW-1:0] NW_I     = IW'(NW);
  typedef enum logic [2:0] {IDLE, WAIT_LAT, CAPTURE, SUB, OUT} state_t;
`else
  localparam logic [IW-1:0] LAST_OUT = IW'(NW-1);
  typedef enum logic [2:0] {IDLE, WAIT_LAT, CAPTURE, OUT} state_t;
`endif

  state_t        state_reg;
  logic [LW-1:0] lat_cnt_reg;
  logic [GW-1:0] gap_cnt_reg;
  logic [IW-1:0] s_idx_reg;
  logic [IW-1:0] out_idx_reg;
  logic [W-1:0]  out_data_reg;
  logic          out_valid_reg;
  logic          out_last_reg;
  logic          busy_reg;
  logic          done_reg;

  logic [W-1:0]  s_buf [NW];
  logic          s_wr;
  logic          hs;
  logic [IW-1:0] ld_idx;
  logic [W-1:0]  ld_word;

`ifdef MM_FINAL_SUB_EN
  logic [IW-1:0] m_idx_reg;
  logic [IW-1:0] sub_idx_reg;
  logic          borrow_reg;
  logic          sel_d_reg;
  logic [W-1:0]  m_buf [NW];
  logic [W-1:0]  d_buf [NW];
  logic          m_wr;
  logic          d_wr;
  logic [W:0]    diff;

  assign m_wr = M_VALID && (m_idx_reg < NW_I) &&
                (state_reg == WAIT_LAT || state_reg == CAPTURE);
  assign d_wr = (state_reg == SUB);
  // Bit W of the widened difference is the borrow out of this word.
  assign diff = {1'b0, s_buf[sub_idx_reg]} - {1'b0, m_buf[sub_idx_reg]} - {{W{1'b0}}, borrow_reg};
`else
  logic unused_m;
  assign unused_m = ^{M_IN, M_VALID};
`endif

  always_comb begin
    s_wr = 1'b0;
    if (state_reg == WAIT_LAT && lat_cnt_reg == '0) s_wr = 1'b1;
    if (state_reg == CAPTURE && gap_cnt_reg == GAP_END) s_wr = 1'b1;
  end

  generate
    for (genvar gi = 0; gi < NW; gi++) begin : g_word
      logic [W-1:0] s_word_reg;
      always_ff @(posedge CLK or posedge RST) begin
        if (RST) s_word_reg <= '0;
        else if (s_wr && s_idx_reg == IW'(gi)) s_word_reg <= S_IN;
      end
      assign s_buf[gi] = s_word_reg;
`ifdef MM_FINAL_SUB_EN
      logic [W-1:0] m_word_reg;
      logic [W-1:0] d_word_reg;
      always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
          m_word_reg <= '0;
          d_word_reg <= '0;
        end else begin
          if (m_wr && m_idx_reg == IW'(gi)) m_word_reg <= M_IN;
          if (d_wr && sub_idx_reg == IW'(gi)) d_word_reg <= diff[W-1:0];
        end
      end
      assign m_buf[gi] = m_word_reg;
      assign d_buf[gi] = d_word_reg;
`endif
    end
  endgenerate

  // Next word to present: the following one on a handshake, else the current one.
  assign hs     = out_valid_reg && OUT_READY;
  assign ld_idx = hs ? out_idx_reg + IW'(1) : out_idx_reg;
`ifdef MM_FINAL_SUB_EN
  assign ld_word = sel_d_reg ? d_buf[ld_idx] : s_buf[ld_idx];
`else
  assign ld_word = s_buf[ld_idx];
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_reg     <= IDLE;
      lat_cnt_reg   <= '0;
      gap_cnt_reg   <= '0;
      s_idx_reg     <= '0;
      out_idx_reg   <= '0;
      out_data_reg  <= '0;
      out_valid_reg <= 1'b0;
      out_last_reg  <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
`ifdef MM_FINAL_SUB_EN
      m_idx_reg     <= '0;
      sub_idx_reg   <= '0;
      borrow_reg    <= 1'b0;
      sel_d_reg     <= 1'b0;
`endif
    end else begin
      done_reg <= 1'b0;
`ifdef MM_FINAL_SUB_EN
      if (m_wr) m_idx_reg <= m_idx_reg + IW'(1);
`endif
      case (state_reg)
        IDLE: begin
          if (START) begin
            state_reg   <= WAIT_LAT;
            busy_reg    <= 1'b1;
            lat_cnt_reg <= LAT_INIT;
            s_idx_reg   <= '0;
`ifdef MM_FINAL_SUB_EN
            m_idx_reg   <= '0;
`endif
          end
        end
        WAIT_LAT: begin
          if (lat_cnt_reg == '0) begin
            state_reg   <= CAPTURE;
            s_idx_reg   <= IW'(1);
            gap_cnt_reg <= '0;
          end else begin
            lat_cnt_reg <= lat_cnt_reg - LW'(1);
          end
        end
        CAPTURE: begin
          if (gap_cnt_reg == GAP_END) begin
            gap_cnt_reg <= '0;
            s_idx_reg   <= s_idx_reg + IW'(1);
            if (s_idx_reg == LAST_W) begin
`ifdef MM_FINAL_SUB_EN
              state_reg   <= SUB;
              sub_idx_reg <= '0;
              borrow_reg  <= 1'b0;
`else
              state_reg   <= OUT;
              out_idx_reg <= '0;
`endif
            end
          end else begin
            gap_cnt_reg <= gap_cnt_reg + GW'(1);
          end
        end
`ifdef MM_FINAL_SUB_EN
        SUB: begin
          borrow_reg  <= diff[W];
          sub_idx_reg <= sub_idx_reg + IW'(1);
          if (sub_idx_reg == LAST_W) begin
            sel_d_reg   <= ~diff[W];
            state_reg   <= OUT;
            out_idx_reg <= '0;
          end
        end
`endif
        OUT: begin
          if (hs) begin
            if (out_last_reg) begin
              state_reg     <= IDLE;
              busy_reg      <= 1'b0;
              done_reg      <= 1'b1;
              out_valid_reg <= 1'b0;
              out_last_reg  <= 1'b0;
              out_data_reg  <= '0;
            end else begin
              out_idx_reg  <= ld_idx;
              out_data_reg <= ld_word;
              out_last_reg <= (ld_idx == LAST_OUT);
            end
          end else if (!out_valid_reg) begin
            out_valid_reg <= 1'b1;
            out_data_reg  <= ld_word;
            out_last_reg  <= (ld_idx == LAST_OUT);
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign OUT_DATA  = out_data_reg;
  assign OUT_VALID = out_valid_reg;
  assign OUT_LAST  = out_last_reg;
  assign BUSY      = busy_reg;
  assign DONE      = done_reg;
endmodule

// File: tb/tb_mm_result_collector.sv
// Directed bench for mm_result_collector (K=32, W=8, SAMPLE_GAP=3, START_LAT=10);
// expectations follow MM_FINAL_SUB_EN as defined for the build.
module tb_mm_result_collector;
  localparam int K  = 32;
  localparam int W  = 8;
  localparam int SG = 3;
  localparam int SL = 10;
  localparam int NW = K/W+1;
`ifdef MM_FINAL_SUB_EN
  localparam int NOUT = NW-1;
`else
  localparam int NOUT = NW;
`endif

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic         START = 1'b0;
  logic [W-1:0] M_IN = '0;
  logic         M_VALID = 1'b0;
  logic [W-1:0] S_IN = '0;
  logic         OUT_READY = 1'b0;
  logic [W-1:0] OUT_DATA;
  logic         OUT_VALID;
  logic         OUT_LAST;
  logic         BUSY;
  logic         DONE;

  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] m_w [NW];
  logic [W-1:0] s_w [NW];
  logic [W-1:0] e_w [NW];

  always #5 CLK = ~CLK;

  mm_result_collector #(.K(K), .W(W), .SAMPLE_GAP(SG), .START_LAT(SL)) dut (
    .CLK(CLK), .RST(RST), .START(START), .M_IN(M_IN), .M_VALID(M_VALID), .S_IN(S_IN),
    .OUT_DATA(OUT_DATA), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_LAST(OUT_LAST),
    .BUSY(BUSY), .DONE(DONE));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_data(input logic [8*NW-1:0] m, input logic [8*NW-1:0] s,
                          input logic [8*NW-1:0] e);
    for (int i = 0; i < NW; i++) begin
      m_w[i] = m[8*i +: 8];
      s_w[i] = s[8*i +: 8];
      e_w[i] = e[8*i +: 8];
    end
  endtask

  // Called at a negedge; START is seen by the following rising edge.
  task automatic do_start();
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
  endtask

  // Drives inputs for edges 1..ncyc after START; S is valid only at the exact sample edges.
  task automatic feed(input int ncyc, input int restart_at);
    for (int c = 1; c <= ncyc; c++) begin
      if (c <= NW) begin
        M_VALID = 1'b1;
        M_IN    = m_w[c-1];
      end else begin
        M_VALID = 1'b0;
        M_IN    = 8'h00;
      end
      if (c >= SL && (c-SL) % SG == 0 && (c-SL)/SG < NW) S_IN = s_w[(c-SL)/SG];
      else S_IN = 8'hEE;
      START = (c == restart_at);
      @(negedge CLK);
    end
    M_VALID = 1'b0;
    S_IN    = 8'hEE;
    START   = 1'b0;
  endtask

  task automatic collect(input string nm, input bit stall);
    int got = 0;
    int cyc = 0;
    int pat = 0;
    bit prev_stall = 1'b0;
    logic [W-1:0] prev_d = '0;
    logic prev_l = 1'b0;
    while (got < NOUT && cyc < 300) begin
      if (prev_stall) begin
        check({nm, "_hold_data"}, 32'(OUT_DATA), 32'(prev_d));
        check({nm, "_hold_last"}, 32'(OUT_LAST), 32'(prev_l));
      end
      OUT_READY = stall ? (pat % 3 == 0) : 1'b1;
      pat++;
      if (OUT_VALID && OUT_READY) begin
        check({nm, "_data"}, 32'(OUT_DATA), 32'(e_w[got]));
        check({nm, "_last"}, 32'(OUT_LAST), 32'(got == NOUT-1));
        $display("%s word %0d = %02h last=%0b", nm, got, OUT_DATA, OUT_LAST);
        got++;
      end
      prev_stall = OUT_VALID && !OUT_READY;
      prev_d = OUT_DATA;
      prev_l = OUT_LAST;
      @(negedge CLK);
      cyc++;
    end
    OUT_READY = 1'b0;
    check({nm, "_words"}, 32'(got), 32'(NOUT));
    check({nm, "_done"}, 32'(DONE), 32'd1);
    check({nm, "_valid_drop"}, 32'(OUT_VALID), 32'd0);
    @(negedge CLK);
    check({nm, "_done_pulse"}, 32'(DONE), 32'd0);
    check({nm, "_idle"}, 32'(BUSY), 32'd0);
  endtask

  task automatic run(input string nm, input bit stall, input int restart_at);
    do_start();
    check({nm, "_busy"}, 32'(BUSY), 32'd1);
    feed(SL + SG*(NW-1), restart_at);
    collect(nm, stall);
  endtask

  initial begin
    @(negedge CLK);
    check("rst_valid", 32'(OUT_VALID), 32'd0);
    check("rst_busy",  32'(BUSY), 32'd0);
    check("rst_done",  32'(DONE), 32'd0);
    check("rst_last",  32'(OUT_LAST), 32'd0);
    check("rst_data",  32'(OUT_DATA), 32'd0);
    RST = 1'b0;
    @(negedge CLK);

`ifdef MM_FINAL_SUB_EN
    set_data(40'h00_00_00_00_F1, 40'h00_00_00_01_00, 40'h00_00_00_00_0F);
`else
    set_data(40'h00_00_00_00_F1, 40'h00_00_00_01_00, 40'h00_00_00_01_00);
`endif
    run("s1", 1'b0, 0);

`ifdef MM_FINAL_SUB_EN
    set_data(40'h00_00_00_00_F1, 40'h00_00_00_00_C8, 40'h00_00_00_00_C8);
`else
    set_data(40'h00_00_00_00_F1, 40'h00_00_00_00_C8, 40'h00_00_00_00_C8);
`endif
    run("s2", 1'b0, 0);

`ifdef MM_FINAL_SUB_EN
    set_data(40'h00_00_00_00_F1, 40'h00_00_00_00_F1, 40'h00_00_00_00_00);
`else
    set_data(40'h00_00_00_00_F1, 40'h00_00_00_00_F1, 40'h00_00_00_00_F1);
`endif
    run("s3", 1'b0, 0);

`ifdef MM_FINAL_SUB_EN
    set_data(40'h00_00_00_00_F1, 40'h00_00_00_01_00, 40'h00_00_00_00_0F);
`else
    set_data(40'h00_00_00_00_F1, 40'h00_00_00_01_00, 40'h00_00_00_01_00);
`endif
    run("s4", 1'b1, SL + SG + 2);

    // Abort after two samples, then rerun with the second data set.
    do_start();
    feed(SL + SG + 1, 0);
    check("s5_busy_before", 32'(BUSY), 32'd1);
    #1 RST = 1'b1;
    #1;
    check("s5_rst_busy",  32'(BUSY), 32'd0);
    check("s5_rst_valid", 32'(OUT_VALID), 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    set_data(40'h00_00_00_00_F1, 40'h00_00_00_00_C8, 40'h00_00_00_00_C8);
    run("s5", 1'b0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
